data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the single-cycle CPU's data port. It accepts
//   MemRead/MemWrite requests with Addr and WriteData, services them after a
//   programmable wait-state count, and returns ReadData with a one-cycle Ready
//   pulse. Stall tells the CPU to freeze the PC and pipeline state until the
//   access completes. Storage is an internal word array.
// PARAMETERS
//   DEPTH_WORDS  256  number of 32-bit words; legal word index 0..DEPTH_WORDS-1
//   ADDR_W       32   width of Addr
//   LATENCY      2    service latency in cycles; legal range 1..16
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   MemRead    in   1       read request (level)
//   MemWrite   in   1       write request (level)
//   Addr       in   ADDR_W  byte address; word index = Addr[ADDR_W-1:2]
//   WriteData  in   32      store data
//   ReadData   out  32      load data; registered, held until next read completes
//   Ready      out  1       one-cycle pulse: access complete
//   Stall      out  1       combinational: CPU must hold
//   AddrErr    out  1       pulses with Ready: misaligned or out-of-range access
// BEHAVIOUR
//   Reset (async): state IDLE, cnt=0, ReadData=0, Ready=0, AddrErr=0, array=0.
//     Stall=0 unless a request is present in IDLE.
//   FSM states: IDLE, WAIT, RESP.
//   IDLE: if MemRead|MemWrite is high at a clock edge, latch Addr, WriteData
//     and op. Load cnt=LATENCY-1. Go to RESP if LATENCY==1, else go to WAIT.
//   WAIT: cnt decrements each edge; when cnt==1, the next state is RESP.
//     Inputs are ignored; the latched copies are used.
//   Edge entering RESP: perform the write, or load ReadData from the array.
//   RESP: Ready=1 for exactly one cycle. Requests are not sampled. Next: IDLE.
//   Latency: counting the capture edge as edge 1, Ready rises on edge LATENCY.
//     Back-to-back requests are serviced every LATENCY+1 cycles.
//   Stall = (IDLE & (MemRead|MemWrite)) | WAIT. Stall=0 in RESP.
//   MemRead and MemWrite both high: the access is a write; ReadData unchanged.
//   Error: Addr[1:0]!=0 or word index >= DEPTH_WORDS. The access completes
//     with normal latency, the array is untouched, and AddrErr=1 with Ready.
//     An erroneous read sets ReadData=0.
//   A successful access drives AddrErr=0 in its RESP cycle.
//   A read leaves the array unchanged; a write leaves ReadData unchanged.
//   Reset mid-operation: the in-flight access is abandoned. A write not yet in
//     RESP is dropped and no Ready pulse is issued.
// TESTING
//   1 Reset: assert rst between edges -> ReadData=0, Ready=0, AddrErr=0
//     immediately; Stall=0 with no request.
//   2 LATENCY=2: write 32'hDEADBEEF @0x10, then read @0x10 -> Stall high for
//     2 cycles per access, one Ready pulse each, ReadData=32'hDEADBEEF.
//   3 Misaligned write 32'h0 @0x11, then read @0x10 -> AddrErr pulse on the
//     write, ReadData=32'hDEADBEEF. Read @0x400 -> AddrErr=1, ReadData=0.
//   4 MemRead=MemWrite=1, 32'hCAFE0001 @0x20 -> acts as a write, ReadData
//     unchanged. A later read @0x20 returns 32'hCAFE0001.
//   5 Write 32'h12345678 @0x24 with LATENCY=3; assert rst in WAIT -> no Ready.
//     A later read @0x24 returns 0.
//   6 LATENCY=1, MemRead held high @0x0 then @0x4 -> Ready on alternate cycles,
//     Stall=0 in each RESP cycle, data returned in order.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-port memory responder: programmable wait states, one-cycle Ready pulse,
// combinational Stall, and address checking against the internal word array.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Ready,
  output logic              Stall,
  output logic              AddrErr
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic              err_q;
  logic [31:0]       read_data_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              req;
  logic              capture;
  logic              enter_resp;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_write;
  logic [ADDR_W-3:0] acc_word;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_err;

  assign req     = MemRead | MemWrite;
  assign capture = (state_q == StIdle) && req;

  // With single-cycle latency the access completes on the capture edge, so the
  // live inputs are used there instead of the latched copies.
  assign acc_addr  = (state_q == StIdle) ? Addr      : addr_q;
  assign acc_wdata = (state_q == StIdle) ? WriteData : wdata_q;
  assign acc_write = (state_q == StIdle) ? MemWrite  : write_q;
  assign acc_word  = acc_addr[ADDR_W-1:2];
  assign acc_idx   = acc_word[IDX_W-1:0];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (64'(acc_word) >= 64'(DEPTH_WORDS));

  assign enter_resp = (state_d == StResp);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= Addr;
        wdata_q <= WriteData;
        write_q <= MemWrite;
      end
      if (enter_resp) begin
        err_q <= acc_err;
        if (!acc_write) begin
          read_data_q <= acc_err ? 32'h0 : mem_q[acc_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enter_resp && acc_write && !acc_err) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign ReadData = read_data_q;
  assign Ready    = (state_q == StResp);
  assign AddrErr  = (state_q == StResp) && err_q;
  assign Stall    = ((state_q == StIdle) && req) || (state_q == StWait);

endmodule
